pool_window_scheduler: RTL

Sequences one min_pooling-style reduction unit across a full feature map stored in single-port SRAM. For each window it:
- fetches the KxK window elements over a read port,
- loads them into the pooling unit and waits for its done,
- captures the result and emits it on a valid/ready output stream.
Sits between the feature-map buffer and the next layer's input FIFO.

---
 rtl/pool_window_scheduler_if.sv | 32 +++
 rtl/pool_window_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_scheduler_if.sv
// Scheduler bundle: SRAM read port, pooling-unit load/run port and the result stream.
// master = scheduler side, slave = memory / pooling unit / downstream side.
interface pool_window_scheduler_if #(
  parameter int IL     = 8,
  parameter int FL     = 12,
  parameter int K      = 2,
  parameter int ADDR_W = 6,
  parameter int IDX_W  = 4
);
  logic                              rd_en;
  logic [ADDR_W-1:0]                 rd_addr;
  logic [IL+FL-1:0]                  rd_data;
  logic [K*K-1:0][IL+FL-1:0]         pool_im;
  logic                              pool_en;
  logic                              pool_input_ready;
  logic [IL+FL-1:0]                  pool_om;
  logic                              pool_done;
  logic                              out_valid;
  logic                              out_ready;
  logic [IL+FL-1:0]                  out_data;
  logic [IDX_W-1:0]                  out_idx;

  modport master (
    output rd_en, rd_addr, pool_im, pool_en, pool_input_ready, out_valid, out_data, out_idx,
    input  rd_data, pool_om, pool_done, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, pool_im, pool_en, pool_input_ready, out_valid, out_data, out_idx,
    output rd_data, pool_om, pool_done, out_ready
  );
endinterface

// File: rtl/pool_window_scheduler.sv
// Walks every KxK window of an SRAM feature map through one pooling unit and streams the results;
// 2*K*K+4 cycles per window with out_ready high, a stalled result holds the next fetch. POOL_SCHED_PERF_EN adds stall/window counters.
module pool_window_scheduler #(
  parameter int IL     = 8,
  parameter int FL     = 12,
  parameter int FM_W   = 8,
  parameter int FM_H   = 8,
  parameter int K      = 2,
  parameter int ADDR_W = $clog2(FM_W*FM_H),
  parameter int IDX_W  = $clog2((FM_W/K)*(FM_H/K))
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic frame_done,
`ifdef POOL_SCHED_PERF_EN
  output logic [31:0]    stall_cycles,
  output logic [IDX_W:0] win_count,
`endif
  pool_window_scheduler_if.master bus
);

  localparam int DW    = IL + FL;
  localparam int KK    = K * K;
  localparam int KK_W  = $clog2(KK);
  localparam int TAP_W = $clog2(KK + 1);
  localparam int LOG2K = $clog2(K);
  localparam int WX    = FM_W / K;
  localparam int WY    = FM_H / K;
  localparam int WX_W  = (WX > 1) ? $clog2(WX) : 1;
  localparam int WY_W  = (WY > 1) ? $clog2(WY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_OUT
  } state_e;

  state_e                  state_q, state_d;
  logic [TAP_W-1:0]        tap_q, tap_d;
  logic [WX_W-1:0]         wx_q, wx_d;
  logic [WY_W-1:0]         wy_q, wy_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    rd_vld_q;
  logic [KK_W-1:0]         rd_tap_q;
  logic [KK-1:0][DW-1:0]   pool_im_q;
  logic [DW-1:0]           out_data_q;
  logic [IDX_W-1:0]        out_idx_q;

  logic                    start_acc;
  logic                    hs;
  logic                    last_win;
  logic                    rd_en_w;
  logic [31:0]             tap_r;
  logic [31:0]             tap_c;

  assign start_acc = (state_q == S_IDLE) && start;
  assign hs        = (state_q == S_OUT) && bus.out_ready;
  assign last_win  = (wx_q == WX_W'(WX - 1)) && (wy_q == WY_W'(WY - 1));
  // The final FETCH cycle issues no read; it only lands the last tap.
  assign rd_en_w   = (state_q == S_FETCH) && (tap_q < TAP_W'(KK));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   if (tap_q == TAP_W'(KK)) state_d = S_LOAD;
      S_LOAD:    state_d = S_RUN;
      S_RUN:     if (bus.pool_done) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUT;
      S_OUT:     if (bus.out_ready) state_d = last_win ? S_IDLE : S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rd_en            = rd_en_w;
    bus.pool_en          = 1'b0;
    bus.pool_input_ready = 1'b0;
    bus.out_valid        = 1'b0;
    case (state_q)
      S_LOAD: begin
        bus.pool_en          = 1'b1;
        bus.pool_input_ready = 1'b1;
      end
      S_RUN:   bus.pool_en   = 1'b1;
      S_OUT:   bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Tap t = r*K + c maps to row wy*K+r, column wx*K+c of the row-major map.
  always_comb begin
    tap_r       = 32'(tap_q) >> LOG2K;
    tap_c       = 32'(tap_q) & 32'(K - 1);
    bus.rd_addr = '0;
    if (rd_en_w) begin
      bus.rd_addr = ADDR_W'((32'(wy_q) * 32'(K) + tap_r) * 32'(FM_W) + 32'(wx_q) * 32'(K) + tap_c);
    end
  end

  always_comb begin
    tap_d = '0;
    if ((state_q == S_FETCH) && (tap_q != TAP_W'(KK))) tap_d = tap_q + TAP_W'(1);

    wx_d  = wx_q;
    wy_d  = wy_q;
    idx_d = idx_q;
    if (start_acc) begin
      wx_d  = '0;
      wy_d  = '0;
      idx_d = '0;
    end else if (hs) begin
      idx_d = idx_q + IDX_W'(1);
      if (wx_q == WX_W'(WX - 1)) begin
        wx_d = '0;
        wy_d = last_win ? '0 : wy_q + WY_W'(1);
      end else begin
        wx_d = wx_q + WX_W'(1);
      end
    end

    busy_d = busy_q;
    if (start_acc) begin
      busy_d = 1'b1;
    end else if (frame_done_q) begin
      busy_d = 1'b0;
    end
    frame_done_d = hs && last_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q        <= '0;
      wx_q         <= '0;
      wy_q         <= '0;
      idx_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_tap_q     <= '0;
      pool_im_q    <= '0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
    end else begin
      tap_q        <= tap_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rd_vld_q     <= rd_en_w;
      rd_tap_q     <= tap_q[KK_W-1:0];
      // Only FETCH writes the window, so it stays frozen from LOAD through CAPTURE.
      if (rd_vld_q) pool_im_q[rd_tap_q] <= bus.rd_data;
      if (state_q == S_CAPTURE) begin
        out_data_q <= bus.pool_om;
        out_idx_q  <= idx_q;
      end
    end
  end

  assign bus.pool_im  = pool_im_q;
  assign bus.out_data = out_data_q;
  assign bus.out_idx  = out_idx_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;

`ifdef POOL_SCHED_PERF_EN
  logic [31:0]    stall_q;
  logic [IDX_W:0] win_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      stall_q <= '0;
      win_q   <= '0;
    end else begin
      if ((state_q == S_OUT) && !bus.out_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (hs) win_q <= win_q + (IDX_W+1)'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign win_count    = win_q;
`endif

endmodule
